drv_test_sequencer: RTL

- Sequences the RISC-V chip driver through a stored list of test vectors: instruction word, expected store address and expected write data.
- Holds the driver in reset, starts the run, and feeds one vector per driver capture.
- Collects the driver's address/data pass flags and reports the run summary: pass/fail counts, first failing index, done and timeout.
- Sits between the vector ROM and the driver, in the program-counter role.

---
 rtl/drv_test_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/drv_test_sequencer.sv
// drv_test_sequencer: steps the chip driver through ROM test vectors and tallies its pass/fail flags
module drv_test_sequencer #(
  parameter int          VEC_AW      = 8,
  parameter int          RST_CYC     = 4,
  parameter int          TIMEOUT_CYC = 1024,
  parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [VEC_AW-1:0] num_vec,
  input  logic [1:0]        core_sel_in,
  output logic              vec_rd_en,
  output logic [VEC_AW-1:0] vec_rd_addr,
  input  logic [31:0]       vec_rd_instr,
  input  logic [31:0]       vec_rd_exp_addr,
  input  logic [31:0]       vec_rd_exp_wdata,
  output logic              drv_reset,
  output logic [1:0]        core_sel,
  output logic [31:0]       instruction,
  output logic [31:0]       output_addr_data,
  output logic [31:0]       input_output_write_data,
  output logic              pc_ready,
  input  logic              pc_valid,
  input  logic              output_addr_data_pass,
  input  logic              output_write_data_pass,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [15:0]       pass_cnt,
  output logic [15:0]       fail_cnt,
  output logic              first_fail_valid,
  output logic [VEC_AW-1:0] first_fail_idx
);
  localparam int RW = $clog2(RST_CYC + 1);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [3:0] {IDLE, RST, FETCH, WAIT, PRESENT, CHECK, FLUSH, DONE, ERR} state_t;
  state_t state;
  logic [VEC_AW:0] idx, n, nxt, idx_m1;
  logic [RW-1:0] rst_cnt;
  logic [WW-1:0] wd_cnt;
  logic skip, pc_valid_q, cap_pass, cap, do_score, res_pass, wd_hit;
  assign cap = pc_valid_q & ~pc_valid;
  assign do_score = (state == CHECK) || (state == FLUSH && cap);
  // the flush capture is scored on the spot, so it uses the live flags
  assign res_pass = (state == FLUSH) ? (output_addr_data_pass & output_write_data_pass) : cap_pass;
  assign nxt = (state == CHECK) ? idx + 1'b1 : idx;
  assign idx_m1 = idx - 1'b1;
  assign wd_hit = wd_cnt == WW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      drv_reset <= 1'b1;
      core_sel <= '0;
      instruction <= '0;
      output_addr_data <= '0;
      input_output_write_data <= '0;
      pc_ready <= 1'b0;
      vec_rd_en <= 1'b0;
      vec_rd_addr <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      timeout <= 1'b0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx <= '0;
      pc_valid_q <= 1'b0;
      cap_pass <= 1'b0;
      skip <= 1'b0;
      idx <= '0;
      n <= '0;
      rst_cnt <= '0;
      wd_cnt <= '0;
    end else begin
      pc_valid_q <= pc_valid;
      if (cap) cap_pass <= output_addr_data_pass & output_write_data_pass;
      if (do_score) begin
        skip <= 1'b0;
        if (!skip && res_pass) pass_cnt <= (&pass_cnt) ? pass_cnt : pass_cnt + 16'd1;
        if (!skip && !res_pass) begin
          fail_cnt <= (&fail_cnt) ? fail_cnt : fail_cnt + 16'd1;
          first_fail_valid <= 1'b1;
          if (!first_fail_valid) first_fail_idx <= idx_m1[VEC_AW-1:0];
        end
      end
      case (state)
        IDLE, DONE, ERR: if (start) begin
          n <= {1'b0, num_vec};
          core_sel <= core_sel_in;
          pass_cnt <= '0;
          fail_cnt <= '0;
          first_fail_valid <= 1'b0;
          first_fail_idx <= '0;
          done <= 1'b0;
          timeout <= 1'b0;
          busy <= 1'b1;
          drv_reset <= 1'b1;
          idx <= '0;
          skip <= 1'b1;
          rst_cnt <= '0;
          state <= RST;
        end
        RST, CHECK: if (state == CHECK || rst_cnt == RW'(RST_CYC - 1)) begin
          drv_reset <= 1'b0;
          idx <= nxt;
          if (nxt == n) begin
            instruction <= NOP_INSTR;
            pc_ready <= 1'b1;
            wd_cnt <= '0;
            state <= FLUSH;
          end else begin
            vec_rd_en <= 1'b1;
            vec_rd_addr <= nxt[VEC_AW-1:0];
            state <= FETCH;
          end
        end else rst_cnt <= rst_cnt + 1'b1;
        FETCH: begin
          vec_rd_en <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          instruction <= vec_rd_instr;
          output_addr_data <= vec_rd_exp_addr;
          input_output_write_data <= vec_rd_exp_wdata;
          pc_ready <= 1'b1;
          wd_cnt <= '0;
          state <= PRESENT;
        end
        PRESENT, FLUSH: if (cap) begin
          pc_ready <= 1'b0;
          busy <= state == PRESENT;
          done <= state == FLUSH;
          state <= (state == PRESENT) ? CHECK : DONE;
        end else if (wd_hit) begin
          pc_ready <= 1'b0;
          busy <= 1'b0;
          done <= 1'b1;
          timeout <= 1'b1;
          drv_reset <= 1'b1;
          state <= ERR;
        end else wd_cnt <= wd_cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
